// File: rtl/prim_pkg.sv
// rtl/prim_pkg.sv - shared stack op encodings and per-op depth table
package prim_pkg;

  typedef enum logic [2:0] {
    STK_NOP   = 3'd0,
    STK_PUSH  = 3'd1,
    STK_POP   = 3'd2,
    STK_SETT  = 3'd3,
    STK_BINOP = 3'd4,
    STK_SWAP  = 3'd5,
    STK_DUP   = 3'd6,
    STK_OVER  = 3'd7
  } stk_op_e;

  typedef struct packed {
    logic [1:0] min_depth;
    logic       grows;
    logic       shrinks;
  } stk_info_t;

  // Minimum entries needed and depth delta (+1 grows, -1 shrinks) for each op.
  function automatic stk_info_t stk_info(stk_op_e op);
    stk_info_t info;
    info = '{min_depth: 2'd0, grows: 1'b0, shrinks: 1'b0};
    case (op)
      STK_PUSH:  info = '{min_depth: 2'd0, grows: 1'b1, shrinks: 1'b0};
      STK_POP:   info = '{min_depth: 2'd1, grows: 1'b0, shrinks: 1'b1};
      STK_SETT:  info = '{min_depth: 2'd1, grows: 1'b0, shrinks: 1'b0};
      STK_BINOP: info = '{min_depth: 2'd2, grows: 1'b0, shrinks: 1'b1};
      STK_SWAP:  info = '{min_depth: 2'd2, grows: 1'b0, shrinks: 1'b0};
      STK_DUP:   info = '{min_depth: 2'd1, grows: 1'b1, shrinks: 1'b0};
      STK_OVER:  info = '{min_depth: 2'd2, grows: 1'b1, shrinks: 1'b0};
      default:   info = '{min_depth: 2'd0, grows: 1'b0, shrinks: 1'b0};
    endcase
    return info;
  endfunction

endpackage

// File: rtl/prim_stack_if.sv
// rtl/prim_stack_if.sv - op strobe and stack view bundle for prim_stack
interface prim_stack_if #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 4
);

  logic                  i_valid;
  logic [2:0]            i_op;
  logic [WIDTH-1:0]      i_dat;
  logic                  i_clr_err;
  logic [WIDTH-1:0]      o_t;
  logic [WIDTH-1:0]      o_n;
  logic [WIDTH-1:0]      o_third;
  logic [DEPTH_LOG2+1:0] o_depth;
  logic                  o_empty;
  logic                  o_full;
  logic                  o_ovf;
  logic                  o_unf;

  modport master (
    output i_valid, i_op, i_dat, i_clr_err,
    input  o_t, o_n, o_third, o_depth, o_empty, o_full, o_ovf, o_unf
  );

  modport slave (
    input  i_valid, i_op, i_dat, i_clr_err,
    output o_t, o_n, o_third, o_depth, o_empty, o_full, o_ovf, o_unf
  );

endinterface

// File: rtl/prim_stack.sv
// rtl/prim_stack.sv - data stack with cached T/N registers and register-file spill area
module prim_stack
  import prim_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  prim_stack_if.slave bus
);

  localparam int MEM_WORDS = 1 << DEPTH_LOG2;
  localparam int DW        = DEPTH_LOG2 + 2;
  localparam logic [DW-1:0] CAP = DW'(MEM_WORDS + 2);

  logic [WIDTH-1:0]      t_q, n_q, t_d, n_d;
  logic [DEPTH_LOG2:0]   sp_q;
  logic [DW-1:0]         depth_q;
  logic                  ovf_q, unf_q;
  logic [WIDTH-1:0]      mem [MEM_WORDS];

  stk_op_e               op;
  stk_info_t             info;
  logic                  has_op, err_unf, err_ovf, do_op;
  logic                  deep2, deep3, mem_wr, mem_rd;
  logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;
  logic [WIDTH-1:0]      mem_top;

  assign op     = stk_op_e'(bus.i_op);
  assign info   = stk_info(op);
  assign wr_idx = sp_q[DEPTH_LOG2-1:0];
  // With sp at MEM_WORDS the low bits are zero, so the wrap lands on the last slot.
  assign rd_idx = wr_idx - 1'b1;

  always_comb begin
    has_op  = bus.i_valid && (op != STK_NOP);
    err_unf = has_op && (depth_q < DW'(info.min_depth));
    err_ovf = has_op && !err_unf && info.grows && (depth_q == CAP);
    do_op   = has_op && !err_unf && !err_ovf;
    deep2   = depth_q >= DW'(2);
    deep3   = depth_q >= DW'(3);
    mem_wr  = do_op && info.grows && deep2;
    mem_rd  = do_op && info.shrinks && deep3;
    mem_top = deep3 ? mem[rd_idx] : '0;
  end

  // Shallow stacks read mem_top as 0, which refills the vacated N slot.
  always_comb begin
    t_d = t_q;
    n_d = n_q;
    case (op)
      STK_PUSH:  begin n_d = t_q;     t_d = bus.i_dat; end
      STK_POP:   begin t_d = n_q;     n_d = mem_top;   end
      STK_SETT:  begin t_d = bus.i_dat;                end
      STK_BINOP: begin t_d = bus.i_dat; n_d = mem_top; end
      STK_SWAP:  begin t_d = n_q;     n_d = t_q;       end
      STK_DUP:   begin n_d = t_q;                      end
      STK_OVER:  begin n_d = t_q;     t_d = n_q;       end
      default:   begin t_d = t_q;     n_d = n_q;       end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      t_q     <= '0;
      n_q     <= '0;
      sp_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (do_op) begin
        t_q <= t_d;
        n_q <= n_d;
        if (info.grows)
          depth_q <= depth_q + DW'(1);
        else if (info.shrinks)
          depth_q <= depth_q - DW'(1);
      end
      if (mem_wr)
        sp_q <= sp_q + 1'b1;
      else if (mem_rd)
        sp_q <= sp_q - 1'b1;
      ovf_q <= (ovf_q && !bus.i_clr_err) || err_ovf;
      unf_q <= (unf_q && !bus.i_clr_err) || err_unf;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_wr)
      mem[wr_idx] <= n_q;
  end

  assign bus.o_t     = t_q;
  assign bus.o_n     = n_q;
  assign bus.o_third = mem_top;
  assign bus.o_depth = depth_q;
  assign bus.o_empty = (depth_q == '0);
  assign bus.o_full  = (depth_q == CAP);
  assign bus.o_ovf   = ovf_q;
  assign bus.o_unf   = unf_q;

endmodule

// File: tb/tb_prim_stack.sv
// tb/tb_prim_stack.sv - directed vector table, corner sequences and queue-model stream for prim_stack
module tb_prim_stack;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, SETT = 3'd3;
  localparam logic [2:0] BINOP = 3'd4, SWAP = 3'd5, DUP = 3'd6, OVER = 3'd7;
  localparam int CAP = 18;

  typedef struct {
    logic        valid;
    logic [2:0]  op;
    logic [15:0] dat;
    logic        clr;
    logic [15:0] t;
    logic [15:0] n;
    logic [15:0] th;
    logic [5:0]  d;
    logic        ovf;
    logic        unf;
  } vec_t;

  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[$];
  logic [15:0] q[$];
  logic m_ovf, m_unf;

  prim_stack_if #(.WIDTH(16), .DEPTH_LOG2(4)) bus ();

  prim_stack #(.WIDTH(16), .DEPTH_LOG2(4)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic addv(input logic v, input logic [2:0] op, input logic [15:0] dat, input logic clr,
                      input logic [15:0] t, input logic [15:0] n, input logic [15:0] th,
                      input logic [5:0] d, input logic ovf, input logic unf);
    vec_t x;
    x.valid = v; x.op = op; x.dat = dat; x.clr = clr;
    x.t = t; x.n = n; x.th = th; x.d = d; x.ovf = ovf; x.unf = unf;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [15:0] et, input logic [15:0] en,
                       input logic [15:0] eth, input logic [5:0] ed, input logic eovf, input logic eunf);
    logic ee, ef;
    ee = (ed == 6'd0);
    ef = (ed == 6'(CAP));
    n_vec++;
    if (bus.o_t !== et || bus.o_n !== en || bus.o_third !== eth || bus.o_depth !== ed ||
        bus.o_empty !== ee || bus.o_full !== ef || bus.o_ovf !== eovf || bus.o_unf !== eunf) begin
      n_bad++;
      $display("FAIL %s: got t=%h n=%h th=%h d=%0d e=%b f=%b ovf=%b unf=%b, want t=%h n=%h th=%h d=%0d e=%b f=%b ovf=%b unf=%b",
               name, bus.o_t, bus.o_n, bus.o_third, bus.o_depth, bus.o_empty, bus.o_full, bus.o_ovf, bus.o_unf,
               et, en, eth, ed, ee, ef, eovf, eunf);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] dat, input logic clr);
    bus.i_valid = v; bus.i_op = op; bus.i_dat = dat; bus.i_clr_err = clr;
    @(posedge i_clk);
    #1;
    bus.i_valid = 1'b0; bus.i_clr_err = 1'b0;
  endtask

  task automatic do_reset();
    bus.i_valid = 1'b0; bus.i_clr_err = 1'b0;
    i_reset_n = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
  endtask

  function automatic int min_of(input logic [2:0] op);
    case (op)
      POP, SETT, DUP:       return 1;
      BINOP, SWAP, OVER:    return 2;
      default:              return 0;
    endcase
  endfunction

  // Queue reference: q[size-1] is top of stack.
  task automatic model_step(input logic v, input logic [2:0] op, input logic [15:0] dat, input logic clr);
    int sz;
    logic [15:0] a;
    sz = q.size();
    if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (v && op != NOP) begin
      if (sz < min_of(op)) m_unf = 1'b1;
      else if ((op == PUSH || op == DUP || op == OVER) && sz == CAP) m_ovf = 1'b1;
      else begin
        case (op)
          PUSH:  q.push_back(dat);
          POP:   a = q.pop_back();
          SETT:  q[sz-1] = dat;
          BINOP: begin a = q.pop_back(); q[sz-2] = dat; end
          SWAP:  begin a = q[sz-1]; q[sz-1] = q[sz-2]; q[sz-2] = a; end
          DUP:   q.push_back(q[sz-1]);
          OVER:  q.push_back(q[sz-2]);
          default: ;
        endcase
      end
    end
  endtask

  task automatic model_check(input string name);
    int sz;
    logic [15:0] et, en, eth;
    sz = q.size();
    et  = (sz >= 1) ? q[sz-1] : 16'h0;
    en  = (sz >= 2) ? q[sz-2] : 16'h0;
    eth = (sz >= 3) ? q[sz-3] : 16'h0;
    check(name, et, en, eth, 6'(sz), m_ovf, m_unf);
  endtask

  initial begin
    bus.i_valid = 1'b0; bus.i_op = NOP; bus.i_dat = 16'h0; bus.i_clr_err = 1'b0;

    // valid op  dat      clr  T        N        third    d   ovf unf
    addv(1, PUSH, 16'h1111, 0, 16'h1111, 16'h0000, 16'h0000, 1, 0, 0);
    addv(1, PUSH, 16'h2222, 0, 16'h2222, 16'h1111, 16'h0000, 2, 0, 0);
    addv(1, PUSH, 16'h3333, 0, 16'h3333, 16'h2222, 16'h1111, 3, 0, 0);
    addv(1, NOP,  16'h9999, 0, 16'h3333, 16'h2222, 16'h1111, 3, 0, 0);
    addv(0, PUSH, 16'h9999, 0, 16'h3333, 16'h2222, 16'h1111, 3, 0, 0);
    addv(1, DUP,  16'h0000, 0, 16'h3333, 16'h3333, 16'h2222, 4, 0, 0);
    addv(1, POP,  16'h0000, 0, 16'h3333, 16'h2222, 16'h1111, 3, 0, 0);
    addv(1, SETT, 16'h0ABC, 0, 16'h0ABC, 16'h2222, 16'h1111, 3, 0, 0);
    addv(1, SWAP, 16'h0000, 0, 16'h2222, 16'h0ABC, 16'h1111, 3, 0, 0);
    addv(1, OVER, 16'h0000, 0, 16'h0ABC, 16'h2222, 16'h0ABC, 4, 0, 0);
    addv(1, BINOP,16'h0055, 0, 16'h0055, 16'h0ABC, 16'h1111, 3, 0, 0);
    addv(1, POP,  16'h0000, 0, 16'h0ABC, 16'h1111, 16'h0000, 2, 0, 0);
    addv(1, POP,  16'h0000, 0, 16'h1111, 16'h0000, 16'h0000, 1, 0, 0);
    addv(1, SWAP, 16'h0000, 0, 16'h1111, 16'h0000, 16'h0000, 1, 0, 1);
    addv(1, NOP,  16'h0000, 1, 16'h1111, 16'h0000, 16'h0000, 1, 0, 0);
    addv(1, OVER, 16'h0000, 0, 16'h1111, 16'h0000, 16'h0000, 1, 0, 1);
    addv(1, POP,  16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    addv(1, POP,  16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
    addv(1, POP,  16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
    addv(0, NOP,  16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    addv(1, SETT, 16'h1234, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
    addv(1, NOP,  16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    addv(1, PUSH, 16'h0005, 0, 16'h0005, 16'h0000, 16'h0000, 1, 0, 0);
    addv(1, PUSH, 16'h0007, 0, 16'h0007, 16'h0005, 16'h0000, 2, 0, 0);
    addv(1, SWAP, 16'h0000, 0, 16'h0005, 16'h0007, 16'h0000, 2, 0, 0);
    addv(1, OVER, 16'h0000, 0, 16'h0007, 16'h0005, 16'h0007, 3, 0, 0);
    addv(1, BINOP,16'h000C, 0, 16'h000C, 16'h0007, 16'h0000, 2, 0, 0);
    addv(1, BINOP,16'h0001, 0, 16'h0001, 16'h0000, 16'h0000, 1, 0, 0);
    addv(1, BINOP,16'h0002, 0, 16'h0001, 16'h0000, 16'h0000, 1, 0, 1);
    addv(1, NOP,  16'h0000, 1, 16'h0001, 16'h0000, 16'h0000, 1, 0, 0);

    repeat (2) @(posedge i_clk);
    #1;
    check("reset_state", 16'h0, 16'h0, 16'h0, 6'd0, 1'b0, 1'b0);
    i_reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].dat, vecs[i].clr);
      check($sformatf("vec%0d", i), vecs[i].t, vecs[i].n, vecs[i].th, vecs[i].d, vecs[i].ovf, vecs[i].unf);
    end

    // Fill to capacity, then overflow and clear/set interplay.
    do_reset();
    for (int k = 1; k <= CAP; k++) drive(1'b1, PUSH, 16'(k), 1'b0);
    check("fill_cap", 16'd18, 16'd17, 16'd16, 6'd18, 1'b0, 1'b0);
    drive(1'b1, PUSH, 16'hFFFF, 1'b0);
    check("push_full", 16'd18, 16'd17, 16'd16, 6'd18, 1'b1, 1'b0);
    drive(1'b1, NOP, 16'h0, 1'b1);
    check("clr_ovf", 16'd18, 16'd17, 16'd16, 6'd18, 1'b0, 1'b0);
    drive(1'b1, OVER, 16'h0, 1'b1);
    check("ovf_set_wins", 16'd18, 16'd17, 16'd16, 6'd18, 1'b1, 1'b0);
    drive(1'b1, NOP, 16'h0, 1'b1);
    for (int k = 1; k <= CAP; k++) begin
      int d;
      drive(1'b1, POP, 16'h0, 1'b0);
      d = CAP - k;
      check($sformatf("drain%0d", k), 16'(d), (d >= 2) ? 16'(d - 1) : 16'h0,
            (d >= 3) ? 16'(d - 2) : 16'h0, 6'(d), 1'b0, 1'b0);
    end

    // Reset asserted mid-cycle during a burst with valid high.
    drive(1'b1, PUSH, 16'hAAAA, 1'b0);
    drive(1'b1, PUSH, 16'hBBBB, 1'b0);
    drive(1'b1, POP, 16'h0, 1'b0);
    bus.i_valid = 1'b1; bus.i_op = PUSH; bus.i_dat = 16'hCCCC;
    #2;
    i_reset_n = 1'b0;
    #1;
    check("async_reset", 16'h0, 16'h0, 16'h0, 6'd0, 1'b0, 1'b0);
    @(posedge i_clk);
    #1;
    check("reset_hold", 16'h0, 16'h0, 16'h0, 6'd0, 1'b0, 1'b0);
    bus.i_dat = 16'h4242;
    i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_valid = 1'b0;
    check("first_after_reset", 16'h4242, 16'h0, 16'h0, 6'd1, 1'b0, 1'b0);

    // Random op stream against the queue model.
    do_reset();
    q.delete();
    m_ovf = 1'b0; m_unf = 1'b0;
    for (int k = 0; k < 600; k++) begin
      logic v, c;
      logic [2:0] op;
      logic [15:0] dat;
      v   = ($urandom_range(0, 9) < 8);
      c   = ($urandom_range(0, 9) == 0);
      op  = (k < 300) ? ((($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : PUSH))
                      : 3'($urandom_range(0, 7));
      dat = 16'($urandom);
      drive(v, op, dat, c);
      model_step(v, op, dat, c);
      model_check($sformatf("rand%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/prim_stack.md
PRIM_STACK -- requirements
Module: prim_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4; the memory part holds 2**DEPTH_LOG2 words, so CAP = 2**DEPTH_LOG2+2 words including cached T/N.
REQ-003 SHALL have i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have i_reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have i_valid  input  1  op strobe; the op is sampled on the rising edge while high.
REQ-006 SHALL have i_op  input  3  operation: 0 NOP, 1 PUSH, 2 POP, 3 SETT, 4 BINOP, 5 SWAP, 6 DUP, 7 OVER.
REQ-007 SHALL have i_dat  input  WIDTH  operand for PUSH/SETT/BINOP.
REQ-008 SHALL have i_clr_err  input  1  clears sticky error flags.
REQ-009 SHALL have o_t, o_n, o_third  output  WIDTH each  top, second and third entries.
REQ-010 SHALL have o_depth  output  DEPTH_LOG2+2  current entry count, range 0..CAP.
REQ-011 SHALL have o_empty, o_full  output  1 each  depth==0 and depth==CAP.
REQ-012 SHALL have o_ovf, o_unf  output  1 each  sticky overflow and underflow flags.

Function
REQ-013 SHALL hold T and N in registers, and entries three and deeper in a register array with pointer sp (next free slot).
REQ-014 SHALL apply accepted ops at the sampling edge, with all outputs showing the result one cycle after i_valid; throughput is one op per cycle with no stall.
REQ-015 SHALL implement per-op behaviour and depth delta as follows:
- PUSH: mem<=N, N<=T, T<=i_dat; +1.
- POP: T<=N, N<=mem top; -1.
- SETT: T<=i_dat; 0.
- BINOP: T<=i_dat, N<=mem top; -1.
- SWAP: T<=N, N<=T; 0.
- DUP: mem<=N, N<=T; +1.
- OVER: mem<=N, N<=T, T<=N; +1.
REQ-016 SHALL require minimum depth before an op is accepted: POP 1, SETT 1, BINOP 2, SWAP 2, DUP 1, OVER 2; PUSH and NOP have no minimum.
REQ-017 SHALL write to / increment sp only when the pre-op depth is >=2, and read from / decrement sp only when the pre-op depth is >=3; otherwise the vacated N or T is loaded with 0.
REQ-018 SHALL drive o_third = mem[sp-1] when depth>=3 and 0 otherwise (combinational from state).
REQ-019 SHALL, for an op that would take depth above CAP: change no state and set o_ovf.
REQ-020 SHALL, for an op below its minimum depth: change no state and set o_unf.
REQ-021 SHALL never wrap sp, which is guaranteed by REQ-019/REQ-020.
REQ-022 SHALL ignore i_op, i_dat and error checks while i_valid is low.
REQ-023 SHALL clear o_ovf/o_unf on i_clr_err; if an error occurs in the same cycle, the set wins.
REQ-024 SHALL treat NOP and error-rejected ops as leaving T, N, the array, sp and depth unchanged.

Reset
REQ-025 SHALL, on i_reset_n low (any time, including mid-op), immediately force T=0, N=0, sp=0, depth=0, o_ovf=0, o_unf=0, hence o_empty=1 and o_full=0; array contents are don't-care.
REQ-026 SHALL accept the first op on the first rising edge after i_reset_n deasserts.

Structure
REQ-027 SHALL place op encodings (STK_NOP..STK_OVER) and the minimum-depth/delta table in shared package prim_pkg for reuse by the Prim core decoder.
REQ-028 SHALL be one module with no sub-modules; the array is inferred as a register file and has no reset.

Verification
REQ-029 SHALL cover: reset, then PUSH 0x1111, 0x2222, 0x3333 -> o_t=0x3333, o_n=0x2222, o_third=0x1111, o_depth=3.
REQ-030 SHALL cover: fill to CAP=18 with PUSH 1..18, then PUSH 0xFFFF -> o_full=1, o_ovf=1, o_t=18, depth stays 18.
REQ-031 SHALL cover: from empty, POP -> o_unf=1, depth 0; then i_clr_err together with another POP -> o_unf stays 1.
REQ-032 SHALL cover: stack [5,7] (T=7), SWAP then OVER -> T=7, N=5, third=7, depth 3; BINOP 0xC -> T=0xC, N=7, depth 2.
REQ-033 SHALL cover: assert i_reset_n low mid-burst with i_valid high -> all outputs are at reset values before the next edge, and no op is applied.
REQ-034 SHALL cover: a random op stream checked each cycle against a queue reference model for T/N/third/depth/flags.
